alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
Downstream stage of the 24-bit ALU (balu_24); consumes its 25-bit result and 3-bit select code.
Captures each valid result into a small FIFO, tags it with the opcode, and derives zero/MSB flags.
Presents results to the consumer over a valid/ready handshake, decoupling the free-running ALU from slower sinks.
Flags any result lost while the FIFO is full.

Parameters:
DATA_W, 25, result width (ALU out width: 24-bit operands + carry/borrow).
OP_W, 3, opcode (select) width.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
clear  input  1  synchronous flush of FIFO and sticky flag.
in_valid  input  1  ALU result valid this cycle.
in_ready  output  1  buffer can accept a result this cycle.
in_result  input  DATA_W  ALU result.
in_select  input  OP_W  opcode that produced in_result.
out_valid  output  1  head entry available.
out_ready  input  1  consumer accepts head entry.
out_result  output  DATA_W  head result.
out_select  output  OP_W  head opcode.
out_zero  output  1  head result == 0.
out_msb  output  1  head result bit DATA_W-1 (carry/borrow).
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow_sticky  output  1  set when a result was offered while full.

Behaviour:
- Reset (reset=0, async): wr/rd pointers=0, count=0, overflow_sticky=0, out_valid=0, in_ready=1. out_result, out_select, out_zero and out_msb are forced to 0 whenever count==0, including during reset. Storage array is not reset.
- Push: in_valid && in_ready. Writes {in_select, in_result} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH). There is no bypass: when full, a same-cycle pop does not admit a push.
- out_valid = (count != 0). out_* are combinational from the head entry.
- Latency: a push into an empty FIFO gives out_valid=1 on the next clock edge.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged and both pointers advance.
- Pop when empty and push when full cannot occur (gated by the handshake).
- Full drop: in_valid=1 && in_ready=0 → result discarded and overflow_sticky set to 1. The flag stays set until clear or reset.
- Clear: has priority over push and pop in the same cycle. Pointers=0, count=0, overflow_sticky=0, and the input that cycle is discarded without setting the flag.
- Reset mid-operation: all buffered entries are lost immediately.
- Flags: out_zero = ~|out_result; out_msb = out_result[DATA_W-1]. Both are 0 when empty.
- No state machine beyond the pointers and count; all arithmetic on pointers wraps modulo DEPTH.

Optional Feature:
ALU_RESULT_PARITY_EN
- Defined: even parity of {in_select, in_result} is computed at push and stored as an extra bit per entry (entry width DATA_W+OP_W+1). It appears on the extra output port out_parity (1 bit), which is 0 when empty.
- Not defined: the out_parity port and the storage bit do not exist; entry width is DATA_W+OP_W.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W=25 and OP_W=3 constants.
  - Opcode enum: ADD=000, SUB=001, DIV=010, REM=011, AND=100, OR=101, XOR=110, XNOR=111.
  - FIFO entry struct {select, result[, parity]}.
- One sub-module, alu_result_fifo_mem: DEPTH x entry register array with one write port and one async read port, no reset on data.

Test Plan:
1. Reset low then high; push {ADD, 25'h1EA6B07} (0xF53586+0xF53581) → next cycle out_valid=1, out_result=25'h1EA6B07, out_select=000, out_msb=1, out_zero=0, count=1.
2. Push {SUB, 25'h0000005}, {AND, 25'h0F53580}, {XOR, 25'h0000007} with out_ready=0 → count=3. Then out_ready=1 → pops in order, count reaches 0 and out_valid=0.
3. Fill with 4 entries, hold in_valid=1 one more cycle → in_ready=0, overflow_sticky=1, count=4, contents unchanged. Pulse clear → count=0, overflow_sticky=0, out_valid=0.
4. With count=2, apply push and pop in the same cycle → count stays 2 and out_result advances to the second entry. Repeat 8 cycles to verify pointer wrap-around and correct order.
5. Push result 25'h0 with opcode XOR → out_zero=1 and out_msb=0. Assert reset mid-stream with 3 entries → out_valid=0, count=0 immediately (asynchronously, before the next clock edge).
6. With ALU_RESULT_PARITY_EN defined, push {ADD, 25'h1EA6B07} → out_parity equals the XOR-reduction of {3'b000, 25'h1EA6B07}.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants, opcode encoding and result-buffer entry layout
// ALU_RESULT_PARITY_EN adds a stored parity bit to each entry.
package alu_pkg;

    localparam int DATA_W = 25;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_DIV  = 3'b010,
        OP_REM  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_XNOR = 3'b111
    } opcode_e;

    typedef struct packed {
        logic [OP_W-1:0]   select;
        logic [DATA_W-1:0] result;
`ifdef ALU_RESULT_PARITY_EN
        logic              parity;
`endif
    } entry_t;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_parity(input logic [OP_W+DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/alu_result_fifo_mem.sv
// rtl/alu_result_fifo_mem.sv - DEPTH x WIDTH register array, one write port, one async read port
// Data storage is deliberately not reset; occupancy is tracked by the owner.
module alu_result_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28,
    parameter int AW    = 2
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FIFO buffer for ALU results with opcode tag, zero/MSB flags and overflow flag
// Optional ALU_RESULT_PARITY_EN: stores even parity per entry and drives out_parity.
module alu_result_buffer #(
    parameter int DATA_W = 25,
    parameter int OP_W   = 3,
    parameter int DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_result,
    input  logic [OP_W-1:0]        in_select,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_result,
    output logic [OP_W-1:0]        out_select,
    output logic                   out_zero,
    output logic                   out_msb,
`ifdef ALU_RESULT_PARITY_EN
    output logic                   out_parity,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow_sticky
);

    import alu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           rd_entry;

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_entry        = '0;
        wr_entry.select = in_select;
        wr_entry.result = in_result;
`ifdef ALU_RESULT_PARITY_EN
        wr_entry.parity = even_parity({in_select, in_result});
`endif
    end

    // Clear wins over everything, so a cleared cycle never writes storage.
    alu_result_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t)),
        .AW    (PTR_W)
    ) u_mem (
        .clock (clock),
        .we    (push && !clear),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            overflow_sticky <= 1'b0;
        end else if (clear) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (in_valid && !in_ready) begin
                overflow_sticky <= 1'b1;
            end
        end
    end

    // Head fields are masked to zero while empty so stale storage never leaks out.
    always_comb begin
        out_result = '0;
        out_select = '0;
        out_zero   = 1'b0;
        out_msb    = 1'b0;
`ifdef ALU_RESULT_PARITY_EN
        out_parity = 1'b0;
`endif
        if (out_valid) begin
            out_result = rd_entry.result;
            out_select = rd_entry.select;
            out_zero   = ~|rd_entry.result;
            out_msb    = rd_entry.result[DATA_W-1];
`ifdef ALU_RESULT_PARITY_EN
            out_parity = rd_entry.parity;
`endif
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_result;
    logic [2:0]  in_select;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_result;
    logic [2:0]  out_select;
    logic        out_zero;
    logic        out_msb;
`ifdef ALU_RESULT_PARITY_EN
    logic        out_parity;
`endif
    logic [2:0]  count;
    logic        overflow_sticky;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_result_buffer dut (
        .clock           (clock),
        .reset           (reset),
        .clear           (clear),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_result       (in_result),
        .in_select       (in_select),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_select      (out_select),
        .out_zero        (out_zero),
        .out_msb         (out_msb),
`ifdef ALU_RESULT_PARITY_EN
        .out_parity      (out_parity),
`endif
        .count           (count),
        .overflow_sticky (overflow_sticky)
    );

    typedef struct {
        logic        clr;
        logic        iv;
        logic [2:0]  sel;
        logic [24:0] res;
        logic        ordy;
        logic [2:0]  e_count;
        logic        e_ready;
        logic [24:0] e_res;
        logic [2:0]  e_sel;
        logic        e_sticky;
    } vec_t;

    typedef struct {
        logic [2:0]  s;
        logic [24:0] r;
    } ent_t;

    vec_t vecs[$];
    ent_t model_q[$];
    logic model_sticky;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic clr, input logic iv, input logic [2:0] sel, input logic [24:0] res,
                           input logic ordy, input logic [2:0] ec, input logic [24:0] eres,
                           input logic [2:0] esel, input logic est);
        vec_t v;
        v.clr = clr; v.iv = iv; v.sel = sel; v.res = res; v.ordy = ordy;
        v.e_count = ec; v.e_ready = (ec < 3'd4); v.e_res = eres; v.e_sel = esel; v.e_sticky = est;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic clr, input logic iv, input logic [2:0] sel,
                         input logic [24:0] res, input logic ordy);
        clear = clr; in_valid = iv; in_select = sel; in_result = res; out_ready = ordy;
    endtask

    task automatic check_model(input string tag);
        logic [24:0] hr;
        logic [2:0]  hs;
        hr = (model_q.size() != 0) ? model_q[0].r : 25'h0;
        hs = (model_q.size() != 0) ? model_q[0].s : 3'h0;
        chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
        chk({tag, "_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
        chk({tag, "_ready"}, 32'(in_ready), 32'(model_q.size() < 4));
        chk({tag, "_result"}, 32'(out_result), 32'(hr));
        chk({tag, "_select"}, 32'(out_select), 32'(hs));
        chk({tag, "_zero"}, 32'(out_zero), 32'((model_q.size() != 0) && (hr == 0)));
        chk({tag, "_msb"}, 32'(out_msb), 32'(hr / 25'h1000000));
        chk({tag, "_sticky"}, 32'(overflow_sticky), 32'(model_sticky));
`ifdef ALU_RESULT_PARITY_EN
        chk({tag, "_parity"}, 32'(out_parity), 32'((model_q.size() != 0) ? ^{hs, hr} : 1'b0));
`endif
    endtask

    // Applies one cycle to the model: clear discards, full offers set the flag, no bypass when full.
    task automatic model_step(input logic clr, input logic iv, input logic [2:0] sel,
                              input logic [24:0] res, input logic ordy);
        int n;
        n = model_q.size();
        if (clr) begin
            model_q.delete();
            model_sticky = 1'b0;
        end else begin
            if (ordy && n > 0) void'(model_q.pop_front());
            if (iv && n < 4) model_q.push_back('{s: sel, r: res});
            if (iv && n >= 4) model_sticky = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'h0, 25'h0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_sticky", 32'(overflow_sticky), 0);
        chk("rst_result", 32'(out_result), 0);
        reset = 1'b1;

        // Tests 1-5 as a vector table
        add_vec(0, 1, 3'd0, 25'h1EA6B07, 0, 1, 25'h1EA6B07, 3'd0, 0);
        add_vec(0, 0, 3'd0, 25'h0,       1, 0, 25'h0,       3'd0, 0);
        add_vec(0, 1, 3'd1, 25'h0000005, 0, 1, 25'h0000005, 3'd1, 0);
        add_vec(0, 1, 3'd4, 25'h0F53580, 0, 2, 25'h0000005, 3'd1, 0);
        add_vec(0, 1, 3'd6, 25'h0000007, 0, 3, 25'h0000005, 3'd1, 0);
        add_vec(0, 0, 3'd0, 25'h0,       1, 2, 25'h0F53580, 3'd4, 0);
        add_vec(0, 0, 3'd0, 25'h0,       1, 1, 25'h0000007, 3'd6, 0);
        add_vec(0, 0, 3'd0, 25'h0,       1, 0, 25'h0,       3'd0, 0);
        for (int i = 0; i < 4; i++)
            add_vec(0, 1, 3'(i), 25'h10 * 25'(i + 1), 0, 3'(i + 1), 25'h10, 3'd0, 0);
        add_vec(0, 1, 3'd7, 25'h50,      0, 4, 25'h10,      3'd0, 1);
        add_vec(0, 1, 3'd7, 25'h60,      1, 3, 25'h20,      3'd1, 1);
        add_vec(1, 1, 3'd7, 25'h70,      1, 0, 25'h0,       3'd0, 0);
        add_vec(0, 1, 3'd2, 25'hA1,      0, 1, 25'hA1,      3'd2, 0);
        add_vec(0, 1, 3'd3, 25'hA2,      0, 2, 25'hA1,      3'd2, 0);
        for (int i = 0; i < 8; i++)
            add_vec(0, 1, 3'(i), 25'hB0 + 25'(i), 1, 2,
                    (i == 0) ? 25'hA2 : 25'hB0 + 25'(i - 1), (i == 0) ? 3'd3 : 3'(i - 1), 0);
        add_vec(0, 0, 3'd0, 25'h0,       1, 1, 25'hB7,      3'd7, 0);
        add_vec(0, 0, 3'd0, 25'h0,       1, 0, 25'h0,       3'd0, 0);
        add_vec(0, 1, 3'd6, 25'h0,       0, 1, 25'h0,       3'd6, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].iv, vecs[i].sel, vecs[i].res, vecs[i].ordy);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_count != 0));
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d_result", i), 32'(out_result), 32'(vecs[i].e_res));
            chk($sformatf("v%0d_select", i), 32'(out_select), 32'(vecs[i].e_sel));
            chk($sformatf("v%0d_zero", i), 32'(out_zero),
                32'(vecs[i].e_count != 0 && vecs[i].e_res == 0));
            chk($sformatf("v%0d_msb", i), 32'(out_msb), 32'(vecs[i].e_res >= 25'h1000000));
            chk($sformatf("v%0d_sticky", i), 32'(overflow_sticky), 32'(vecs[i].e_sticky));
        end

        // Asynchronous reset with three entries buffered
        drive(0, 1, 3'd1, 25'h111, 0);
        @(posedge clock); #1;
        drive(0, 1, 3'd2, 25'h222, 0);
        @(posedge clock); #1;
        chk("pre_rst_count", 32'(count), 3);
        drive(0, 0, 3'd0, 25'h0, 0);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_ready", 32'(in_ready), 1);
        chk("async_rst_result", 32'(out_result), 0);
        @(posedge clock); #1;
        reset = 1'b1;

`ifdef ALU_RESULT_PARITY_EN
        drive(0, 1, 3'd0, 25'h1EA6B07, 0);
        @(posedge clock); #1;
        chk("parity_add", 32'(out_parity), 32'(^{3'b000, 25'h1EA6B07}));
        drive(0, 1, 3'd1, 25'h1EA6B07, 1);
        @(posedge clock); #1;
        chk("parity_sub", 32'(out_parity), 32'(^{3'b001, 25'h1EA6B07}));
        drive(1, 0, 3'd0, 25'h0, 0);
        @(posedge clock); #1;
`endif

        // Randomized run against the queue model
        model_q.delete();
        model_sticky = 1'b0;
        drive(1, 0, 3'd0, 25'h0, 0);
        @(posedge clock); #1;
        for (int c = 0; c < 400; c++) begin
            logic        clr, iv, ordy;
            logic [2:0]  sel;
            logic [24:0] res;
            clr  = ($urandom_range(0, 39) == 0);
            iv   = ($urandom_range(0, 99) < 65);
            ordy = ($urandom_range(0, 99) < 45);
            sel  = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       res = 25'h0;
                1:       res = 25'h1000000 | 25'($urandom);
                default: res = 25'($urandom);
            endcase
            drive(clr, iv, sel, res, ordy);
            model_step(clr, iv, sel, res, ordy);
            @(posedge clock); #1;
            check_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
